sprite_motion_scheduler: RTL and testbench
==========================================

Name: sprite_motion_scheduler

Overview:
Per-frame motion controller for the N sprite positions consumed by VGA_driver. It sequences a single shared step/reflect datapath across every sprite and axis once per frame, and commits all new positions atomically during vertical blanking. A config handshake lets the host place sprites and set velocities between frame updates.

Parameters:
N_SPRITES, 4, number of sprites; index width is clog2(N_SPRITES).
SCREEN_W, 1600, active columns.
SCREEN_H, 1200, active rows.
SPRITE_SIZE, 127, sprite edge in pixels. ROW_MAX = SCREEN_H-SPRITE_SIZE (1073); COL_MAX = SCREEN_W-SPRITE_SIZE (1473).
VEL_W, 8, signed velocity width in pixels per frame.
GRAVITY, 1, row velocity increment per frame (used only with GRAVITY_EN).

Ports:
clock_162  in  1  pixel clock; the only clock.
rst  in  1  asynchronous, active-high reset.
frame_start  in  1  single-cycle pulse at start of vertical blanking.
cfg_valid  in  1  config request.
cfg_ready  out  1  config accepted when valid&&ready.
cfg_sel  in  1  0 = write velocity, 1 = write position.
cfg_idx  in  clog2(N_SPRITES)  target sprite.
cfg_row  in  11  row value; velocity uses the low VEL_W bits, signed.
cfg_col  in  12  col value; velocity uses the low VEL_W bits, signed.
busy  out  1  frame update in progress.
update_done  out  1  one-cycle pulse on commit.
frame_overrun  out  1  sticky; frame_start arrived while busy.
sprite_row  out  [N_SPRITES-1:0][10:0]  committed rows, top-left corner.
sprite_col  out  [N_SPRITES-1:0][11:0]  committed cols, top-left corner.

Behaviour:
- Reset: all outputs 0, shadow positions and velocities 0, FSM in IDLE, so cfg_ready=1. Reset mid-update aborts the update: nothing is committed and update_done stays 0.
- FSM states: IDLE, STEP_ROW, STEP_COL, COMMIT.
  - IDLE + frame_start: go to STEP_ROW, idx=0.
  - STEP_ROW: go to STEP_COL.
  - STEP_COL: if idx==N_SPRITES-1, go to COMMIT; otherwise idx++ and go to STEP_ROW.
  - COMMIT: go to IDLE.
- Timing: for frame_start sampled at cycle 0, busy=1 on cycles 1..2N+1 and update_done pulses at cycle 2N+1 (9 for N=4). Outputs change only on that edge, and all sprites change together.
- Step: one axis per cycle through the shared datapath.
  - Compute in 13-bit signed: p' = p + v.
  - If p'<0: p = -p', v = -v.
  - If p'>MAX: p = 2*MAX - p', v = -v.
  - Otherwise p = p'.
  - A single reflection is sufficient because |v|≤128 < MAX.
  - Negating -128 saturates to +127.
- cfg_ready = (state==IDLE).
  - Velocity writes load the signed velocities.
  - Position writes load the shadow position only, clamped to [0,MAX] per axis; the display follows at the next commit.
  - cfg accepted in the same cycle as frame_start: the write lands first, and the update uses the new values.
- frame_start while busy is ignored and sets frame_overrun, which is cleared only by rst.
- An out-of-range cfg_idx (non-power-of-two N) is accepted and discarded.

Optional Feature:
GRAVITY_EN
- Defined: in STEP_ROW, after reflection, v_row += GRAVITY, saturating at +2^(VEL_W-1)-1.
- Undefined: velocities change only by reflection or config writes; the GRAVITY parameter is unused.

Decomposition:
- Shared package sprite_pkg holds:
  - typedefs row_t (11b), col_t (12b), vel_t (signed VEL_W), and state_t enum;
  - constants SCREEN_W, SCREEN_H, SPRITE_SIZE.
- Sub-module axis_step: combinational step and reflect for one axis, taking pos, vel and max and returning new_pos and new_vel. It is instanced once and shared between the row and col axes.

Test Plan:
1. Sprite0 pos(100,100), vel(5,-3), frame_start -> at cycle 9 row0=105, col0=97, update_done=1; other sprites unchanged.
2. col 1470, vel_col +10 -> col 1466, vel_col -10; next frame -> 1456.
3. row 2, vel_row -5 -> row 3, vel_row +5. Row 50, vel -128 -> row 78, vel +127 (saturated).
4. Position write of row 2000, col 4000 -> clamped to 1073 and 1473 after the next commit; sprite_row/sprite_col unchanged before the commit.
5. cfg_valid held across a frame -> cfg_ready=0 on cycles 1..9 and accepted on cycle 10. frame_start at cycle 4 -> ignored, frame_overrun=1.
6. rst asserted at cycle 4 of an update -> outputs immediately 0, no update_done; the next frame_start runs normally. With GRAVITY_EN: vel_row 0 -> 1 after the first frame, and row advances by 1 on the second frame.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and screen constants for the sprite motion scheduler
package sprite_pkg;

  localparam int SCREEN_W    = 1600;
  localparam int SCREEN_H    = 1200;
  localparam int SPRITE_SIZE = 127;
  localparam int VEL_W       = 8;

  typedef logic [10:0]             row_t;
  typedef logic [11:0]             col_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {IDLE, STEP_ROW, STEP_COL, COMMIT} state_t;

endpackage

// File: rtl/sprite_motion_scheduler_if.sv
// rtl/sprite_motion_scheduler_if.sv - host config handshake for sprite placement and velocity
interface sprite_motion_scheduler_if #(
  parameter int N_SPRITES = 4
) ();
  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sel;
  logic [IDX_W-1:0] cfg_idx;
  logic [10:0]      cfg_row;
  logic [11:0]      cfg_col;

  modport master (output cfg_valid, cfg_sel, cfg_idx, cfg_row, cfg_col, input cfg_ready);
  modport slave  (input cfg_valid, cfg_sel, cfg_idx, cfg_row, cfg_col, output cfg_ready);
endinterface

// File: rtl/axis_step.sv
// rtl/axis_step.sv - combinational step-and-reflect for one axis, shared by row and col
module axis_step #(
  parameter int VEL_W = 8
) (
  input  logic [11:0]             pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic [11:0]             max,
  output logic [11:0]             new_pos,
  output logic signed [VEL_W-1:0] new_vel
);
  localparam logic signed [VEL_W-1:0] V_MIN = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] V_MAX = ~V_MIN;

  logic signed [12:0]      w_sum;
  logic signed [VEL_W-1:0] w_neg;

  assign w_sum = $signed({1'b0, pos}) + $signed({{(13-VEL_W){vel[VEL_W-1]}}, vel});
  assign w_neg = (vel == V_MIN) ? V_MAX : -vel;

  // Reflected results always land in [0,max], so 12-bit modular arithmetic is exact.
  always_comb begin
    new_pos = w_sum[11:0];
    new_vel = vel;
    if (w_sum < 0) begin
      new_pos = -w_sum[11:0];
      new_vel = w_neg;
    end else if (w_sum > $signed({1'b0, max})) begin
      new_pos = max + max - w_sum[11:0];
      new_vel = w_neg;
    end
  end
endmodule

// File: rtl/sprite_motion_scheduler.sv
// rtl/sprite_motion_scheduler.sv - per-frame sprite motion sequencer with atomic commit
// Optional GRAVITY_EN: adds GRAVITY to each row velocity every frame, saturating.
module sprite_motion_scheduler #(
  parameter int N_SPRITES   = 4,
  parameter int SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int SPRITE_SIZE = sprite_pkg::SPRITE_SIZE,
  parameter int VEL_W       = sprite_pkg::VEL_W,
  parameter int GRAVITY     = 1
) (
  input  logic                        clock_162,
  input  logic                        rst,
  input  logic                        frame_start,
  sprite_motion_scheduler_if.slave    cfg,
  output logic                        busy,
  output logic                        update_done,
  output logic                        frame_overrun,
  output logic [N_SPRITES-1:0][10:0]  sprite_row,
  output logic [N_SPRITES-1:0][11:0]  sprite_col
);
  import sprite_pkg::*;

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [11:0] ROW_MAX = 12'(SCREEN_H - SPRITE_SIZE);
  localparam logic [11:0] COL_MAX = 12'(SCREEN_W - SPRITE_SIZE);
  localparam logic signed [VEL_W:0] V_SAT = (VEL_W+1)'((1 << (VEL_W-1)) - 1);
`ifdef GRAVITY_EN
  localparam int GRAV_INC = GRAVITY;
`else
  localparam int GRAV_INC = GRAVITY * 0;
`endif

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  row_t                    r_row  [N_SPRITES];
  col_t                    r_col  [N_SPRITES];
  logic signed [VEL_W-1:0] r_vrow [N_SPRITES];
  logic signed [VEL_W-1:0] r_vcol [N_SPRITES];
  logic                    r_update_done;
  logic                    r_overrun;
  logic [N_SPRITES-1:0][10:0] r_disp_row;
  logic [N_SPRITES-1:0][11:0] r_disp_col;

  logic                    w_is_col, w_last, w_idx_ok;
  logic [11:0]             w_pos, w_max, w_new_pos;
  logic signed [VEL_W-1:0] w_vel, w_new_vel, w_vrow_next;
  logic signed [VEL_W:0]   w_vsum;

  assign w_is_col = (r_state == STEP_COL);
  assign w_pos    = w_is_col ? r_col[r_idx] : {1'b0, r_row[r_idx]};
  assign w_vel    = w_is_col ? r_vcol[r_idx] : r_vrow[r_idx];
  assign w_max    = w_is_col ? COL_MAX : ROW_MAX;
  assign w_last   = (int'(r_idx) == N_SPRITES - 1);
  assign w_idx_ok = (int'(cfg.cfg_idx) < N_SPRITES);

  axis_step #(.VEL_W(VEL_W)) u_step (
    .pos     (w_pos),
    .vel     (w_vel),
    .max     (w_max),
    .new_pos (w_new_pos),
    .new_vel (w_new_vel)
  );

  assign w_vsum      = {w_new_vel[VEL_W-1], w_new_vel} + (VEL_W+1)'(GRAV_INC);
  assign w_vrow_next = (w_vsum > V_SAT) ? V_SAT[VEL_W-1:0] : w_vsum[VEL_W-1:0];

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_update_done <= 1'b0;
      r_overrun     <= 1'b0;
      r_disp_row    <= '0;
      r_disp_col    <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        r_row[i]  <= '0;
        r_col[i]  <= '0;
        r_vrow[i] <= '0;
        r_vcol[i] <= '0;
      end
    end else begin
      r_update_done <= 1'b0;
      if (frame_start && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (cfg.cfg_valid && w_idx_ok) begin
            if (cfg.cfg_sel) begin
              r_row[cfg.cfg_idx] <= ({1'b0, cfg.cfg_row} > ROW_MAX) ? ROW_MAX[10:0] : cfg.cfg_row;
              r_col[cfg.cfg_idx] <= (cfg.cfg_col > COL_MAX) ? COL_MAX : cfg.cfg_col;
            end else begin
              r_vrow[cfg.cfg_idx] <= cfg.cfg_row[VEL_W-1:0];
              r_vcol[cfg.cfg_idx] <= cfg.cfg_col[VEL_W-1:0];
            end
          end
          if (frame_start) begin
            r_state <= STEP_ROW;
            r_idx   <= '0;
          end
        end
        STEP_ROW: begin
          r_row[r_idx]  <= w_new_pos[10:0];
          r_vrow[r_idx] <= w_vrow_next;
          r_state       <= STEP_COL;
        end
        STEP_COL: begin
          r_col[r_idx]  <= w_new_pos;
          r_vcol[r_idx] <= w_new_vel;
          if (w_last) begin
            // Last sprite's col is still in flight, so bypass it into the display copy.
            for (int i = 0; i < N_SPRITES; i++) begin
              r_disp_row[i] <= r_row[i];
              r_disp_col[i] <= (i == N_SPRITES - 1) ? w_new_pos : r_col[i];
            end
            r_update_done <= 1'b1;
            r_state       <= COMMIT;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= STEP_ROW;
          end
        end
        COMMIT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready  = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign update_done    = r_update_done;
  assign frame_overrun  = r_overrun;
  assign sprite_row     = r_disp_row;
  assign sprite_col     = r_disp_col;
endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// tb/tb_sprite_motion_scheduler.sv - scoreboard bench for sprite_motion_scheduler
module tb_sprite_motion_scheduler;
  localparam int N       = 4;
  localparam int ROW_MAX = 1073;
  localparam int COL_MAX = 1473;

  logic clock_162 = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic busy, update_done, frame_overrun;
  logic [N-1:0][10:0] sprite_row;
  logic [N-1:0][11:0] sprite_col;

  sprite_motion_scheduler_if #(.N_SPRITES(N)) cfg_if ();

  sprite_motion_scheduler #(.N_SPRITES(N)) dut (
    .clock_162     (clock_162),
    .rst           (rst),
    .frame_start   (frame_start),
    .cfg           (cfg_if),
    .busy          (busy),
    .update_done   (update_done),
    .frame_overrun (frame_overrun),
    .sprite_row    (sprite_row),
    .sprite_col    (sprite_col)
  );

  always #5 clock_162 = ~clock_162;

  typedef struct {int idx; int row; int col;} exp_t;
  exp_t sb[$];
  int m_row[N], m_col[N], m_vr[N], m_vc[N];
  int mc_row[N], mc_col[N];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_162);
    #1;
  endtask

  function automatic int negsat(input int v);
    return (v == -128) ? 127 : -v;
  endfunction

  function automatic int sext8(input int x);
    int v;
    v = x & 255;
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic mstep(input int p, input int v, input int mx, input bit is_row,
                       output int np, output int nv);
    int s;
    s  = p + v;
    np = s;
    nv = v;
    if (s < 0) begin
      np = -s;
      nv = negsat(v);
    end else if (s > mx) begin
      np = 2 * mx - s;
      nv = negsat(v);
    end
`ifdef GRAVITY_EN
    if (is_row) nv = (nv + 1 > 127) ? 127 : nv + 1;
`endif
  endtask

  task automatic model_frame();
    int p, v;
    for (int i = 0; i < N; i++) begin
      mstep(m_row[i], m_vr[i], ROW_MAX, 1'b1, p, v);
      m_row[i] = p;
      m_vr[i]  = v;
      mstep(m_col[i], m_vc[i], COL_MAX, 1'b0, p, v);
      m_col[i] = p;
      m_vc[i]  = v;
      mc_row[i] = m_row[i];
      mc_col[i] = m_col[i];
      sb.push_back('{i, m_row[i], m_col[i]});
    end
  endtask

  task automatic model_cfg(input bit sel, input int idx, input int r, input int c);
    if (sel) begin
      m_row[idx] = (r > ROW_MAX) ? ROW_MAX : r;
      m_col[idx] = (c > COL_MAX) ? COL_MAX : c;
    end else begin
      m_vr[idx] = sext8(r);
      m_vc[idx] = sext8(c);
    end
  endtask

  task automatic drive_cfg(input bit sel, input int idx, input int r, input int c);
    cfg_if.cfg_sel = sel;
    cfg_if.cfg_idx = idx[1:0];
    cfg_if.cfg_row = r[10:0];
    cfg_if.cfg_col = c[11:0];
  endtask

  task automatic cfg_write(input bit sel, input int idx, input int r, input int c);
    drive_cfg(sel, idx, r, c);
    cfg_if.cfg_valid = 1'b1;
    check("cfg_ready_idle", cfg_if.cfg_ready, 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    model_cfg(sel, idx, r, c);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("row%0d", e.idx), sprite_row[e.idx], e.row);
      check($sformatf("col%0d", e.idx), sprite_col[e.idx], e.col);
    end
  endtask

  task automatic run_frame(input bit same_cfg, input bit sel, input int idx, input int r, input int c);
    int cyc;
    if (same_cfg) begin
      drive_cfg(sel, idx, r, c);
      cfg_if.cfg_valid = 1'b1;
      model_cfg(sel, idx, r, c);
    end
    model_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cyc = 1;
    check("busy_c1", busy, 1);
    check("cfg_ready_c1", cfg_if.cfg_ready, 0);
    while (update_done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("done_cycle", cyc, 9);
    check("busy_c9", busy, 1);
    check_sb();
    tick();
    check("done_pulse", update_done, 0);
    check("busy_c10", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    cfg_if.cfg_valid = 1'b0;
    drive_cfg(1'b0, 0, 0, 0);
    repeat (3) tick();
    check("rst_rows", sprite_row, 0);
    check("rst_cols", sprite_col, 0);
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);
    check("rst_overrun", frame_overrun, 0);
    check("rst_cfg_ready", cfg_if.cfg_ready, 1);
    rst = 1'b0;
    tick();

    // basic move; position write stays in the shadow until commit
    cfg_write(1'b1, 0, 100, 100);
    cfg_write(1'b0, 0, 5, -3);
    check("shadow_only_row0", sprite_row[0], 0);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("tp1_row0", sprite_row[0], 105);
    check("tp1_col0", sprite_col[0], 97);
    check("tp1_row1", sprite_row[1], 0);

    // right-edge reflection
    cfg_write(1'b1, 1, 500, 1470);
    cfg_write(1'b0, 1, 0, 10);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("tp2_col1_a", sprite_col[1], 1466);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("tp2_col1_b", sprite_col[1], 1456);

    // top-edge reflection and -128 saturation
    cfg_write(1'b1, 2, 2, 0);
    cfg_write(1'b0, 2, -5, 0);
    cfg_write(1'b1, 3, 50, 0);
    cfg_write(1'b0, 3, -128, 0);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("tp3_row2", sprite_row[2], 3);
    check("tp3_row3", sprite_row[3], 78);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("tp3_row3_next", sprite_row[3], 205);

    // clamped position write
    cfg_write(1'b0, 0, 0, 0);
    cfg_write(1'b1, 0, 2000, 4000);
    check("tp4_precommit_row0", sprite_row[0], mc_row[0]);
    check("tp4_precommit_col0", sprite_col[0], mc_col[0]);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("tp4_row0", sprite_row[0], 1073);
    check("tp4_col0", sprite_col[0], 1473);

    // config accepted alongside frame_start lands first
    run_frame(1'b1, 1'b0, 2, 0, 20);
    check("same_cycle_col2", sprite_col[2], 20);

    // config held across a frame, plus frame_start while busy
    model_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    drive_cfg(1'b0, 1, 3, -7);
    cfg_if.cfg_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("held_cfg_ready_c%0d", c), cfg_if.cfg_ready, 0);
      if (c == 9) begin
        check("tp5_done_c9", update_done, 1);
        check_sb();
      end
      frame_start = (c == 4);
      tick();
    end
    frame_start = 1'b0;
    check("held_cfg_ready_c10", cfg_if.cfg_ready, 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    model_cfg(1'b0, 1, 3, -7);
    check("overrun_set", frame_overrun, 1);
    check("overrun_no_restart", busy, 0);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("overrun_sticky", frame_overrun, 1);

    // reset in the middle of an update
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_rows", sprite_row, 0);
    check("midrst_cols", sprite_col, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", frame_overrun, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      tick();
      if (update_done === 1'b1) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    for (int i = 0; i < N; i++) begin
      m_row[i] = 0;
      m_col[i] = 0;
      m_vr[i]  = 0;
      m_vc[i]  = 0;
    end
    sb.delete();
    cfg_write(1'b1, 0, 10, 20);
    cfg_write(1'b0, 0, 0, 2);
    run_frame(1'b0, 1'b0, 0, 0, 0);
    check("post_rst_row0_a", sprite_row[0], 10);
    check("post_rst_col0_a", sprite_col[0], 22);
    run_frame(1'b0, 1'b0, 0, 0, 0);
`ifdef GRAVITY_EN
    check("post_rst_row0_b", sprite_row[0], 11);
`else
    check("post_rst_row0_b", sprite_row[0], 10);
`endif
    check("post_rst_col0_b", sprite_col[0], 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
